// File: rtl/multiply_arbiter.sv
// Round-robin arbiter sharing one registered 18x18 signed fixed-point multiplier
// between N_REQ requesters; results return tagged with the requester index.

module multiply (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic signed [17:0] a,
  input  logic signed [17:0] b,
  output logic signed [35:0] p
);
  always_ff @(posedge clk) begin
    if (rst)     p <= '0;
    else if (ce) p <= a * b;
  end
endmodule

module multiply_arbiter #(
  parameter int WDTH    = 18,
  parameter int N_REQ   = 4,
  parameter int ID_WDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*WDTH-1:0]   in_x,
  input  logic [N_REQ*WDTH-1:0]   in_y,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic [ID_WDTH-1:0]      out_id,
  output logic [WDTH-1:0]         out_z,
  output logic                    busy
);
  localparam int STAGES = 3;

  logic [ID_WDTH-1:0]     rr_ptr;
  logic [N_REQ-1:0]       grant;
  logic [ID_WDTH-1:0]     grant_idx;
  logic                   found;
  logic signed [WDTH-1:0] x_sel, y_sel;

  logic [STAGES:1]        vld_pipe;
  logic [ID_WDTH-1:0]     id1, id2;
  logic signed [17:0]     x1, y1;
  logic signed [35:0]     prod;

  // Search offsets 1..N_REQ from the last grant; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    found     = 1'b0;
    x_sel     = '0;
    y_sel     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rst_n && !found && in_valid[i] && (i == (int'(rr_ptr) + k) % N_REQ)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_WDTH'(i);
          x_sel     = in_x[i*WDTH +: WDTH];
          y_sel     = in_y[i*WDTH +: WDTH];
        end
      end
    end
  end

  assign in_ready = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= ID_WDTH'(N_REQ - 1);
      vld_pipe <= '0;
      id1      <= '0;
      id2      <= '0;
      x1       <= '0;
      y1       <= '0;
    end else begin
      if (found) rr_ptr <= grant_idx;
      vld_pipe <= {vld_pipe[STAGES-1:1], found};
      id1      <= grant_idx;
      id2      <= id1;
      x1       <= 18'(x_sel);
      y1       <= 18'(y_sel);
    end
  end

  multiply u_mul (
    .clk (clk),
    .rst (~rst_n),
    .ce  (1'b1),
    .a   (x1),
    .b   (y1),
    .p   (prod)
  );

  // Output registers hold their last result between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_id <= '0;
      out_z  <= '0;
    end else if (vld_pipe[2]) begin
      out_id <= id2;
      out_z  <= WDTH'(prod >>> (WDTH - 1));
    end
  end

  assign out_valid = vld_pipe[3];
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_multiply_arbiter.sv
// Directed bench for multiply_arbiter: reset, fairness, skipping, arithmetic corners, mid-flight reset.

module tb_multiply_arbiter;
  localparam int WDTH = 18, N_REQ = 4, ID_WDTH = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_REQ-1:0]      in_valid;
  logic [N_REQ*WDTH-1:0] in_x, in_y;
  logic [N_REQ-1:0]      in_ready;
  logic                  out_valid;
  logic [ID_WDTH-1:0]    out_id;
  logic [WDTH-1:0]       out_z;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  // expected in-flight entries, slot 3 is what the output shows this cycle
  logic [3:1]  ev;
  logic [1:0]  eid [1:3];
  logic [17:0] ez  [1:3];

  multiply_arbiter #(.WDTH(WDTH), .N_REQ(N_REQ), .ID_WDTH(ID_WDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input int x, input int y);
    in_x[i*WDTH +: WDTH] = x[17:0];
    in_y[i*WDTH +: WDTH] = y[17:0];
  endtask

  // One clock cycle: drive, check, advance the expected pipeline.
  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] er, input int zexp);
    logic [1:0] gid;
    rst_n    = r;
    in_valid = v;
    #1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev[3]);
    chk("busy", busy, |ev);
    if (ev[3]) begin
      chk("out_id", out_id, eid[3]);
      chk("out_z", out_z, ez[3]);
    end
    @(posedge clk);
    #1;
    gid = 2'd0;
    for (int i = 0; i < N_REQ; i++) if (er[i]) gid = 2'(i);
    if (!r) begin
      ev = '0;
    end else begin
      ev     = {ev[2:1], |er};
      eid[3] = eid[2]; eid[2] = eid[1]; eid[1] = gid;
      ez[3]  = ez[2];  ez[2]  = ez[1];  ez[1]  = zexp[17:0];
    end
  endtask

  initial begin
    ev       = '0;
    for (int i = 1; i <= 3; i++) begin eid[i] = '0; ez[i] = '0; end
    rst_n    = 1'b0;
    in_valid = '1;
    in_x     = '0;
    in_y     = '0;
    for (int i = 0; i < N_REQ; i++) setop(i, 65536, i * 16384);
    @(posedge clk);
    #1;

    // reset held with every requester asking
    repeat (3) begin
      cyc(1'b0, 4'hF, 4'h0, 0);
      chk("rst_out_z", out_z, 18'd0);
      chk("rst_out_id", out_id, 2'd0);
    end

    // fairness: 0.5 * i*0.125 = i*0.0625 -> i*8192
    for (int c = 0; c < 12; c++)
      cyc(1'b1, 4'hF, 4'(1 << (c % 4)), (c % 4) * 8192);

    // only 1 and 3 valid: strict alternation, no idle
    for (int c = 0; c < 6; c++)
      cyc(1'b1, 4'b1010, (c % 2) ? 4'b1000 : 4'b0010, (c % 2) ? 24576 : 8192);

    // single multiply 0.5*0.5 from requester 2, then let it drain
    setop(2, 65536, 65536);
    cyc(1'b1, 4'b0100, 4'b0100, 32768);
    repeat (4) cyc(1'b1, 4'b0000, 4'b0000, 0);

    // lone requester held five cycles
    repeat (5) cyc(1'b1, 4'b0100, 4'b0100, 32768);

    // arithmetic corners through requester 0
    setop(0, -131072, -131072); cyc(1'b1, 4'b0001, 4'b0001, -131072);
    setop(0, -65536, 65536);    cyc(1'b1, 4'b0001, 4'b0001, -32768);
    setop(0, 131071, 1);        cyc(1'b1, 4'b0001, 4'b0001, 0);
    setop(0, -1, 1);            cyc(1'b1, 4'b0001, 4'b0001, -1);
    repeat (3) cyc(1'b1, 4'b0000, 4'b0000, 0);

    // mid-flight reset: three acceptances, one reset cycle, in-flight entries vanish
    setop(0, 65536, 0);
    cyc(1'b1, 4'hF, 4'b0010, 8192);
    cyc(1'b1, 4'hF, 4'b0100, 16384);
    cyc(1'b1, 4'hF, 4'b1000, 24576);
    cyc(1'b0, 4'hF, 4'b0000, 0);
    chk("midrst_out_z", out_z, 18'd0);
    cyc(1'b1, 4'hF, 4'b0001, 0);
    repeat (4) cyc(1'b1, 4'b0000, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
